lmsm_sequencer: RTL
===================

Name: lmsm_sequencer

Overview:
Controller that sequences Load-Multiple / Store-Multiple (LM/SM) instructions in the pipelined core. It accepts one LM/SM request from the decode/execute stage, then walks the 8-bit register mask from LSB to MSB. Each memory access drives the data-memory port with base+index, the matching register index and the correct read/write strobe. It also stalls upstream pipeline stages until the sequence completes. It sits between the execute stage and the data-memory port/register-file write mux.

Parameters:
ADDR_W, 16, width of base and memory address.
NREG, 8, number of architectural registers and width of reg_mask.
IDX_W, 3, width of reg_idx; must equal clog2(NREG).

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  reset; synchronous, active-low
start  input  1  request pulse; accepted only in IDLE
is_store  input  1  1 = SM (memory writes), 0 = LM (register writes)
base_addr  input  ADDR_W  starting memory address, sampled on accept
reg_mask  input  NREG  register select mask, sampled on accept; bit i selects Ri
flush  input  1  pipeline flush; aborts the sequence
mem_ready  input  1  memory completes the current access this cycle
busy  output  1  high from accept until the DONE cycle inclusive
stall_pipe  output  1  stalls fetch/decode; equals busy
mem_addr  output  ADDR_W  current access address
mem_rd  output  1  read strobe (LM)
mem_wr  output  1  write strobe (SM)
reg_idx  output  IDX_W  register read (SM) or written (LM) by the current access
rf_we  output  1  register-file write enable for LM data
done  output  1  one-cycle pulse at sequence end

Behaviour:
- Reset values, held while reset_n=0 at a clock edge:
  - state=IDLE.
  - busy, stall_pipe, mem_rd, mem_wr, rf_we, done = 0.
  - mem_addr=0, reg_idx=0.
  - Internal mask, base and index registers = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches base_addr, reg_mask, is_store and sets index=0.
  - If the latched mask is non-zero, go to RUN; if the mask is zero, go to DONE with no memory access.
  - start is ignored in RUN and DONE (no queueing).
- RUN, combinational from the registered state:
  - reg_idx = position of the lowest set bit of the pending mask.
  - mem_addr = base + index, modulo 2^ADDR_W (0xFFFF+1 wraps to 0x0000).
  - mem_rd = ~is_store, mem_wr = is_store.
  - rf_we = ~is_store & mem_ready.
- RUN, access handshake:
  - An access completes in any cycle with mem_ready=1. At that edge, clear the pending bit and increment index.
  - With mem_ready=0, hold mem_addr, reg_idx and the strobes stable.
  - Once the pending mask becomes 0 after a completion, go to DONE.
  - Timing: with mem_ready tied high, one access per cycle; sequence latency = popcount(mask) + 1 cycles from accept to the done pulse.
- DONE:
  - done=1 and busy=1 for exactly one cycle; strobes low.
  - Next state IDLE.
  - A start in the DONE cycle is ignored.
- flush:
  - Any state → IDLE at the next edge.
  - Strobes and busy low from the next cycle; no done pulse.
  - An access completing in the flush cycle still asserts rf_we that cycle.
- Reset mid-sequence: identical to flush, plus all registers return to their reset values.
- Only the mask bits 0..NREG-1 are used; priority is lowest index first.

Optional Feature:
Macro LMSM_BASE_WB_EN.
- Defined:
  - Adds output base_wb_we (1) and output base_wb_data (ADDR_W).
  - In the DONE cycle, base_wb_we=1 and base_wb_data = latched base + popcount(latched mask), modulo 2^ADDR_W.
  - Both are 0 otherwise and at reset.
  - Not asserted on flush.
- Not defined: ports absent; behaviour otherwise identical.

Test Plan:
- Basic LM: start, is_store=0, base=0x1000, mask=0xA5, mem_ready=1 → cycles 1-4 give mem_addr 0x1000/0x1001/0x1002/0x1003 with reg_idx 0/2/5/7, mem_rd=1 and rf_we=1; done in cycle 5; busy low in cycle 6.
- SM with wait states: is_store=1, base=0x0200, mask=0x81, mem_ready low for 2 cycles per access → mem_wr held with addr 0x0200/reg 0 for 3 cycles, then 0x0201/reg 7 for 3 cycles; rf_we never asserts; done 1 cycle later.
- Empty mask: mask=0x00 → no mem_rd/mem_wr; done one cycle after accept; busy high for exactly 1 cycle.
- Wrap: base=0xFFFF, mask=0x03 → addresses 0xFFFF then 0x0000; with LMSM_BASE_WB_EN, base_wb_data=0x0001 in the DONE cycle.
- Flush and reset: mask=0xFF, flush asserted during the 3rd access → IDLE next cycle, no done; repeat with reset_n=0 instead → all outputs 0 next edge. A start issued during RUN is ignored (no second sequence).
- Back-to-back: a start in the DONE cycle is ignored; a start in the following IDLE cycle is accepted with a new mask=0x10 → a single access with reg_idx=4.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask LSB-first, issuing one data-memory access per set bit.
// Optional base-register writeback enabled by defining LMSM_BASE_WB_EN.
module lmsm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    input  logic              flush,
    input  logic              mem_ready,
    output logic              busy,
    output logic              stall_pipe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [IDX_W-1:0]  reg_idx,
    output logic              rf_we,
    output logic              done
`ifdef LMSM_BASE_WB_EN
    ,
    output logic              base_wb_we,
    output logic [ADDR_W-1:0] base_wb_data
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // One extra bit so the access counter can reach NREG.
    localparam int CNT_W = IDX_W + 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic              store_q, store_d;
    logic [CNT_W-1:0]  index_q, index_d;

    logic              run_s;
    logic [IDX_W-1:0]  low_idx_s;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] m);
        lowest_set = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

    assign run_s     = (state_q == S_RUN);
    assign low_idx_s = lowest_set(mask_q);

    // Next-state and datapath update; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        mask_d  = mask_q;
        store_d = store_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    mask_d  = reg_mask;
                    store_d = is_store;
                    index_d = '0;
                    state_d = (reg_mask != '0) ? S_RUN : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (mem_ready) begin
                    mask_d  = mask_q & (mask_q - NREG'(1));
                    index_d = index_q + CNT_W'(1);
                    state_d = (mask_d == '0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            mask_q  <= '0;
            store_q <= 1'b0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            store_q <= store_d;
            index_q <= index_d;
        end
    end

    // Access outputs are combinational from the registered state so they hold during wait states.
    always_comb begin
        busy       = (state_q != S_IDLE);
        stall_pipe = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        if (run_s) begin
            mem_addr = base_q + ADDR_W'(index_q);
            reg_idx  = low_idx_s;
            mem_rd   = ~store_q;
            mem_wr   = store_q;
            rf_we    = ~store_q & mem_ready;
        end else begin
            mem_addr = '0;
            reg_idx  = '0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            rf_we    = 1'b0;
        end
    end

`ifdef LMSM_BASE_WB_EN
    // In DONE the access counter equals the popcount of the latched mask.
    always_comb begin
        if (state_q == S_DONE) begin
            base_wb_we   = 1'b1;
            base_wb_data = base_q + ADDR_W'(index_q);
        end else begin
            base_wb_we   = 1'b0;
            base_wb_data = '0;
        end
    end
`endif

endmodule
